// File: rtl/edge_event_arbiter_if.sv
// Bundle of edge-pulse inputs, event handshake and overflow flags for edge_event_arbiter.
// The producer/consumer side uses master; the arbiter uses slave.
interface edge_event_arbiter_if #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
);
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic            evt_ready;
    logic            clr_overflow;
    logic            evt_valid;
    logic [CW-1:0]   evt_ch;
    logic            evt_type;
    logic [N_CH-1:0] overflow;

    modport master (
        output rise_pulse, fall_pulse, evt_ready, clr_overflow,
        input  evt_valid, evt_ch, evt_type, overflow
    );

    modport slave (
        input  rise_pulse, fall_pulse, evt_ready, clr_overflow,
        output evt_valid, evt_ch, evt_type, overflow
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Collects per-channel rise/fall edge pulses into pending bits and serialises them
// through a round-robin arbiter onto a single valid/ready event port.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input logic                 clk,
    input logic                 rst_n,
    edge_event_arbiter_if.slave bus
);

    logic [N_CH-1:0] rise_pend;
    logic [N_CH-1:0] fall_pend;
    logic [N_CH-1:0] fall_first;
    logic [N_CH-1:0] overflow_q;
    logic [CW-1:0]   rr_ptr;
    logic            evt_valid_q;
    logic [CW-1:0]   evt_ch_q;
    logic            evt_type_q;

    logic            load_en;
    logic            grant_vld;
    logic [CW-1:0]   grant_ch;
    logic            grant_type;
    logic [CW-1:0]   cand;
    logic [N_CH-1:0] gr_rise;
    logic [N_CH-1:0] gr_fall;
    logic [N_CH-1:0] rise_rem;
    logic [N_CH-1:0] fall_rem;
    logic [N_CH-1:0] new_rise;
    logic [N_CH-1:0] new_fall;
    logic [N_CH-1:0] ovf_set;
    logic [N_CH-1:0] ff_next;

    assign load_en = !evt_valid_q || bus.evt_ready;

    // First channel with anything pending, scanning upward from rr_ptr with wrap.
    always_comb begin : pick
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = CW'((int'(rr_ptr) + k) % N_CH);
            if (!grant_vld && (rise_pend[cand] || fall_pend[cand])) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
        grant_type = (rise_pend[grant_ch] && fall_pend[grant_ch]) ? fall_first[grant_ch]
                                                                  : fall_pend[grant_ch];
    end

    always_comb begin : next_pending
        gr_rise = '0;
        gr_fall = '0;
        if (load_en && grant_vld) begin
            if (grant_type) gr_fall[grant_ch] = 1'b1;
            else            gr_rise[grant_ch] = 1'b1;
        end
        rise_rem = rise_pend & ~gr_rise;
        fall_rem = fall_pend & ~gr_fall;
        new_rise = bus.rise_pulse & ~rise_rem;
        new_fall = bus.fall_pulse & ~fall_rem;
        ovf_set  = (bus.rise_pulse & rise_rem) | (bus.fall_pulse & fall_rem);
        // fall_first tracks which surviving event is older; a tie in an empty channel favours rise.
        ff_next  = fall_first;
        for (int i = 0; i < N_CH; i++) begin
            if (new_rise[i] && new_fall[i]) ff_next[i] = 1'b0;
            else if (new_rise[i])           ff_next[i] = fall_rem[i];
            else if (new_fall[i])           ff_next[i] = !rise_rem[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pend   <= '0;
            fall_pend   <= '0;
            fall_first  <= '0;
            overflow_q  <= '0;
            rr_ptr      <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_type_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rise_pend  <= bus.rise_pulse | rise_rem;
            fall_pend  <= bus.fall_pulse | fall_rem;
            fall_first <= ff_next;
            overflow_q <= (bus.clr_overflow ? '0 : overflow_q) | ovf_set;
            if (load_en) begin
                evt_valid_q <= grant_vld;
                if (grant_vld) begin
                    evt_ch_q   <= grant_ch;
                    evt_type_q <= grant_type;
                    rr_ptr     <= (grant_ch == CW'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
                end
            end
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_ch    = evt_ch_q;
    assign bus.evt_type  = evt_type_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench: per-channel event queues model the arbiter, plus directed scenarios
// with hand-computed expectations and a long randomized run.
module tb_edge_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_event_arbiter_if #(.N_CH(N), .CW(CW)) bus ();

    edge_event_arbiter #(.N_CH(N), .CW(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: each channel holds an age-ordered queue of pending event types (0 rise, 1 fall).
    int          q[N][$];
    bit          m_valid;
    int          m_ch;
    bit          m_type;
    bit [N-1:0]  m_ovf;
    int          rr;

    function automatic bit has(input int ch, input int t);
        for (int j = 0; j < q[ch].size(); j++)
            if (q[ch][j] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) q[c].delete();
        m_valid = 0;
        m_ch    = 0;
        m_type  = 0;
        m_ovf   = '0;
        rr      = 0;
    endtask

    task automatic model_step();
        bit load;
        int g;
        load = !m_valid || bus.evt_ready;
        g    = -1;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (rr + k) % N;
                if (g < 0 && q[c].size() > 0) g = c;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_ch    = g;
                m_type  = bit'(q[g].pop_front());
                rr      = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        if (bus.clr_overflow) m_ovf = '0;
        for (int c = 0; c < N; c++) begin
            if (bus.rise_pulse[c]) begin
                if (has(c, 0)) m_ovf[c] = 1'b1;
                else           q[c].push_back(0);
            end
            if (bus.fall_pulse[c]) begin
                if (has(c, 1)) m_ovf[c] = 1'b1;
                else           q[c].push_back(1);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            check("model valid", 32'(bus.evt_valid), 32'(m_valid));
            if (m_valid) begin
                check("model ch", 32'(bus.evt_ch), 32'(m_ch));
                check("model type", 32'(bus.evt_type), 32'(m_type));
            end
            check("model overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.rise_pulse   = '0;
        bus.fall_pulse   = '0;
        bus.evt_ready    = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        nxt();
        check("reset valid", 32'(bus.evt_valid), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);
        nxt();
        rst_n = 1'b1;

        // Single event: one edge of latency, then presented for exactly one cycle.
        do_reset();
        bus.evt_ready  = 1'b1;
        bus.rise_pulse = 4'b0100;
        nxt();
        bus.rise_pulse = '0;
        check("single latency", 32'(bus.evt_valid), 32'd0);
        nxt();
        check("single valid", 32'(bus.evt_valid), 32'd1);
        check("single ch", 32'(bus.evt_ch), 32'd2);
        check("single type", 32'(bus.evt_type), 32'd0);
        nxt();
        check("single once", 32'(bus.evt_valid), 32'd0);

        // Fairness: all four channels at once, twice; order restarts at ch0.
        do_reset();
        bus.evt_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            bus.rise_pulse = 4'b1111;
            nxt();
            bus.rise_pulse = '0;
            nxt();
            for (int c = 0; c < N; c++) begin
                check("fair valid", 32'(bus.evt_valid), 32'd1);
                check("fair ch", 32'(bus.evt_ch), 32'(c));
                nxt();
            end
            check("fair drained", 32'(bus.evt_valid), 32'd0);
        end

        // Backpressure: held event stays stable, queued event follows acceptance.
        do_reset();
        bus.rise_pulse = 4'b0010;
        nxt();
        bus.rise_pulse = '0;
        check("bp idle", 32'(bus.evt_valid), 32'd0);
        nxt();
        bus.fall_pulse = 4'b1000;
        for (int s = 0; s < 5; s++) begin
            check("bp hold valid", 32'(bus.evt_valid), 32'd1);
            check("bp hold ch", 32'(bus.evt_ch), 32'd1);
            check("bp hold type", 32'(bus.evt_type), 32'd0);
            nxt();
            bus.fall_pulse = '0;
        end
        bus.evt_ready = 1'b1;
        nxt();
        check("bp next ch", 32'(bus.evt_ch), 32'd3);
        check("bp next type", 32'(bus.evt_type), 32'd1);
        nxt();
        check("bp drained", 32'(bus.evt_valid), 32'd0);

        // Order: ch1 occupies the output while ch0 collects a fall then a rise.
        do_reset();
        bus.rise_pulse = 4'b0010;
        nxt();
        bus.rise_pulse = '0;
        bus.fall_pulse = 4'b0001;
        nxt();
        bus.fall_pulse = '0;
        check("order hold ch", 32'(bus.evt_ch), 32'd1);
        nxt();
        bus.rise_pulse = 4'b0001;
        nxt();
        bus.rise_pulse = '0;
        bus.evt_ready  = 1'b1;
        nxt();
        check("order first ch", 32'(bus.evt_ch), 32'd0);
        check("order first fall", 32'(bus.evt_type), 32'd1);
        nxt();
        check("order second ch", 32'(bus.evt_ch), 32'd0);
        check("order second rise", 32'(bus.evt_type), 32'd0);
        nxt();
        check("order drained", 32'(bus.evt_valid), 32'd0);

        // Overflow: repeated ch1 rise while stalled; one delivery; clear.
        do_reset();
        bus.rise_pulse = 4'b0001;
        nxt();
        bus.rise_pulse = 4'b0010;
        nxt();
        check("ovf none yet", 32'(bus.overflow), 32'd0);
        check("ovf hold ch0", 32'(bus.evt_ch), 32'd0);
        nxt();
        bus.rise_pulse = '0;
        check("ovf flag", 32'(bus.overflow), 32'b0010);
        bus.evt_ready = 1'b1;
        nxt();
        check("ovf deliver ch", 32'(bus.evt_ch), 32'd1);
        check("ovf deliver type", 32'(bus.evt_type), 32'd0);
        nxt();
        check("ovf single", 32'(bus.evt_valid), 32'd0);
        check("ovf sticky", 32'(bus.overflow), 32'b0010);
        bus.clr_overflow = 1'b1;
        nxt();
        bus.clr_overflow = 1'b0;
        check("ovf cleared", 32'(bus.overflow), 32'd0);

        // Reset mid-operation: three pending, one presented, overflow set.
        do_reset();
        bus.fall_pulse = 4'b1110;
        nxt();
        bus.fall_pulse = 4'b0100;
        bus.rise_pulse = 4'b0001;
        nxt();
        bus.fall_pulse = '0;
        bus.rise_pulse = '0;
        check("pre-rst valid", 32'(bus.evt_valid), 32'd1);
        check("pre-rst ch", 32'(bus.evt_ch), 32'd1);
        check("pre-rst type", 32'(bus.evt_type), 32'd1);
        check("pre-rst overflow", 32'(bus.overflow), 32'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 32'(bus.evt_valid), 32'd0);
        check("async rst ch", 32'(bus.evt_ch), 32'd0);
        check("async rst type", 32'(bus.evt_type), 32'd0);
        check("async rst overflow", 32'(bus.overflow), 32'd0);
        nxt();
        nxt();
        rst_n = 1'b1;
        bus.evt_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            nxt();
            check("post-rst quiet", 32'(bus.evt_valid), 32'd0);
        end

        // Randomized run checked by the model process.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] r1, r2, f1, f2;
            r1 = N'($urandom);
            r2 = N'($urandom);
            f1 = N'($urandom);
            f2 = N'($urandom);
            bus.rise_pulse   = r1 & r2;
            bus.fall_pulse   = f1 & f2;
            bus.evt_ready    = ((cyc % 200) < 40) ? ($urandom_range(0, 7) == 0)
                                                  : ($urandom_range(0, 3) != 0);
            bus.clr_overflow = ($urandom_range(0, 15) == 0);
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rand rst valid", 32'(bus.evt_valid), 32'd0);
                nxt();
                idle_inputs();
                nxt();
                rst_n = 1'b1;
            end else begin
                nxt();
            end
        end
        idle_inputs();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
